spi_rx_frame_checker: RTL and testbench
=======================================

Name: spi_rx_frame_checker

Overview:
- Receive-side companion to the team's SPI transmit master.
- Sits directly downstream: takes the master's sdi / cs / out_spi_clk wires and oversamples them in its own clk domain.
- Deserialises each MSB-first frame and presents a parallel word with a one-cycle valid pulse.
- Flags malformed frames (wrong bit count).
- Used as the on-board loopback checker and as the receive front end of the next board stage.

Parameters:
- QUANTITY_BITS, 12, expected bits per frame; width of data_out.
- SYNC_STAGES, 2, flip-flops in each input synchroniser (minimum 2).
- CNT_W, 8, width of the internal bit counter; must satisfy 2^CNT_W > QUANTITY_BITS+1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- sdi  in  1  serial data from the master; asynchronous to clk.
- cs  in  1  chip select from the master, active low; asynchronous.
- spi_clk  in  1  SPI clock from the master (idle low, data valid on rising edge); asynchronous.
- data_out  out  QUANTITY_BITS  last correctly received word; holds until the next good frame.
- data_valid  out  1  one-cycle pulse when data_out updates.
- frame_err  out  1  one-cycle pulse when a frame ends with a bit count other than QUANTITY_BITS.
- busy  out  1  high while a frame is being received (FSM in RECEIVE).

Behaviour:
- Reset values, applied at the first clk edge with reset=1:
  - data_out=0, data_valid=0, frame_err=0, busy=0.
  - FSM=IDLE, bit counter=0, shift register=0.
  - sdi and spi_clk synchroniser flops=0.
  - cs synchroniser flops and cs_prev=0, so no falling edge is seen after reset.
- Synchronisation: each input passes through SYNC_STAGES flops. The edge detector compares the synchronised value with a 1-flop delayed copy:
  - cs_fall = prev 1 and now 0.
  - cs_rise = prev 0 and now 1.
  - sclk_rise = prev 0 and now 1.
- Input timing requirement: spi_clk high and low phases, and the cs-high gap between frames, must each be at least SYNC_STAGES+1 clk periods. No behaviour is defined below this limit.
- FSM IDLE:
  - cs_fall -> RECEIVE; clear the bit counter and the overflow flag.
  - sclk_rise and cs_rise are ignored.
- FSM RECEIVE:
  - On sclk_rise: shift register <= {shift[QUANTITY_BITS-2:0], sdi_sync}.
  - Also on sclk_rise: the bit counter increments, saturating at QUANTITY_BITS+1. Reaching QUANTITY_BITS+1 sets overflow.
  - On cs_rise -> IDLE.
    - If count == QUANTITY_BITS: data_out <= shift register (including a shift made in the same cycle) and data_valid=1 for exactly one cycle.
    - Otherwise (short, zero-length or overflowing frame): frame_err=1 for one cycle and data_out holds.
- Simultaneous sclk_rise and cs_rise in one cycle: the bit is shifted and counted first, then the frame is evaluated using the updated count.
- cs_fall while already in RECEIVE cannot occur, because cs_rise is required first.
- Latency: with edge 0 defined as the first clk edge whose first sync flop captures cs=1, data_valid / frame_err are high during the cycle after edge SYNC_STAGES+1.
- data_valid and frame_err are never high together. Neither is high outside the cycle following a cs_rise handled in RECEIVE.
- Reset mid-frame:
  - Returns to IDLE.
  - The partial frame is discarded with no pulse.
  - Because cs_sync resets to 0, the ongoing low cs is not treated as a new frame. Reception resumes only after cs goes high and then low again.
- busy = (state == RECEIVE), registered.

Decomposition:
- Shared package spi_pkg:
  - FSM state constants IDLE=0, RECEIVE=1.
  - Default QUANTITY_BITS=12.
  - The bit-period constant shared with the transmit master.
- Sub-module spi_sync_edge (SYNC_STAGES flops plus prev flop; outputs level, rise, fall; parameter RESET_VAL). Instantiated three times, for sdi, cs and spi_clk.

Test Plan:
1. Master-style frame, 12 bits 110011001100, phases of 100 clk each -> one data_valid pulse, data_out=12'hCCC, frame_err never high, busy high from cs_fall+SYNC_STAGES+1 until the frame ends.
2. Short frame of 11 rising edges, then cs high -> frame_err pulse once, data_valid stays 0, data_out keeps its previous value (12'hCCC).
3. Overflow frame of 13 edges with data 0x1FFF -> frame_err pulse once, data_out unchanged, counter saturates with no wrap to a false match.
4. Reset asserted for 1 cycle after 5 bits while cs is low; the master finishes that frame, then sends 12'hA5A -> no pulse for the interrupted frame, then data_valid with data_out=12'hA5A.
5. spi_clk toggling 20 times with cs held high -> busy, data_valid and frame_err all stay 0.
6. Back-to-back frames 12'h001 then 12'h800 with a cs-high gap of SYNC_STAGES+1 clk; second frame's last spi_clk rise coincides (after sync) with cs_rise -> two data_valid pulses in order, with data_out 12'h001 then 12'h800.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions used by the transmit master and the receive-side frame checker.
package spi_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RECEIVE = 1'b1
  } spi_state_t;

  localparam int SPI_QUANTITY_BITS = 12;
  // Half of one SPI bit period in system clocks, as generated by the transmit master.
  localparam int SPI_HALF_PERIOD_CLKS = 100;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input with registered level, rise and fall outputs.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_rise;
  logic                   r_fall;

  // r_prev doubles as the level output so level, rise and fall all describe the same sample.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_prev <= r_sync[SYNC_STAGES-1];
      r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
      r_fall <= ~r_sync[SYNC_STAGES-1] & r_prev;
    end
  end

  assign o_level = r_prev;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/spi_rx_frame_checker.sv
// Oversampling SPI receiver: deserialises MSB-first frames, pulses data_valid on a correct
// bit count and frame_err on any other count.
module spi_rx_frame_checker
  import spi_pkg::*;
#(
  parameter int QUANTITY_BITS = SPI_QUANTITY_BITS,
  parameter int SYNC_STAGES   = 2,
  parameter int CNT_W         = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sdi,
  input  logic                     cs,
  input  logic                     spi_clk,
  output logic [QUANTITY_BITS-1:0] data_out,
  output logic                     data_valid,
  output logic                     frame_err,
  output logic                     busy
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(QUANTITY_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(QUANTITY_BITS + 1);

  logic w_sdi_lvl;
  logic w_cs_rise;
  logic w_cs_fall;
  logic w_sclk_rise;
  logic w_unused_sdi_rise;
  logic w_unused_sdi_fall;
  logic w_unused_cs_lvl;
  logic w_unused_sclk_lvl;
  logic w_unused_sclk_fall;

  spi_state_t               r_state;
  spi_state_t               w_state_nxt;
  logic [CNT_W-1:0]         r_cnt;
  logic [CNT_W-1:0]         w_cnt_nxt;
  logic                     r_ovf;
  logic                     w_ovf_nxt;
  logic [QUANTITY_BITS-1:0] r_shift;
  logic [QUANTITY_BITS-1:0] w_shift_nxt;
  logic [QUANTITY_BITS-1:0] r_data;
  logic                     r_valid;
  logic                     r_err;
  logic                     w_load;
  logic                     w_err;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdi (
    .i_clk   (clk),
    .i_reset (reset),
    .i_d     (sdi),
    .o_level (w_sdi_lvl),
    .o_rise  (w_unused_sdi_rise),
    .o_fall  (w_unused_sdi_fall)
  );

  // cs resets to 0 so a cs already low when reset releases is not mistaken for a new frame.
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_cs (
    .i_clk   (clk),
    .i_reset (reset),
    .i_d     (cs),
    .o_level (w_unused_cs_lvl),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .i_clk   (clk),
    .i_reset (reset),
    .i_d     (spi_clk),
    .o_level (w_unused_sclk_lvl),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_unused_sclk_fall)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_cs_fall) w_state_nxt = RECEIVE;
      RECEIVE: if (w_cs_rise) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // A bit arriving in the same cycle as cs_rise is shifted and counted before the frame is judged.
  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    w_shift_nxt = r_shift;
    w_load      = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cs_fall) begin
          w_cnt_nxt = '0;
          w_ovf_nxt = 1'b0;
        end
      end
      RECEIVE: begin
        if (w_sclk_rise) begin
          w_shift_nxt = {r_shift[QUANTITY_BITS-2:0], w_sdi_lvl};
          if (r_cnt != CNT_SAT) w_cnt_nxt = r_cnt + 1'b1;
          if (w_cnt_nxt == CNT_SAT) w_ovf_nxt = 1'b1;
        end
        if (w_cs_rise) begin
          if ((w_cnt_nxt == CNT_FULL) && !w_ovf_nxt) w_load = 1'b1;
          else                                       w_err  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_ovf   <= w_ovf_nxt;
      r_shift <= w_shift_nxt;
      r_valid <= w_load;
      r_err   <= w_err;
      if (w_load) r_data <= w_shift_nxt;
    end
  end

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign frame_err  = r_err;
  assign busy       = (r_state == RECEIVE);

endmodule

// File: tb/tb_spi_rx_frame_checker.sv
// Bench for spi_rx_frame_checker: directed and randomised SPI frames against a frame-level model.
module tb_spi_rx_frame_checker;

  localparam int Q     = 12;
  localparam int S     = 2;
  localparam int CNT_W = 8;
  localparam int INF   = 32'h3fff_ffff;

  logic         clk = 1'b0;
  logic         reset;
  logic         sdi;
  logic         cs;
  logic         spi_clk;
  logic [Q-1:0] data_out;
  logic         data_valid;
  logic         frame_err;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int b_start = INF;
  int b_end   = INF;
  bit mon_en  = 1'b0;

  // Expected pulses, one entry per completed frame: kind, data_out value, cycle of cs rise.
  logic         e_err  [0:1023];
  logic [Q-1:0] e_data [0:1023];
  int           e_cyc  [0:1023];
  int           wr_idx = 0;
  int           rd_idx = 0;
  logic [Q-1:0] m_held = '0;
  bit           tx_bits[$];

  always #5 clk = ~clk;

  spi_rx_frame_checker #(.QUANTITY_BITS(Q), .SYNC_STAGES(S), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .sdi        (sdi),
    .cs         (cs),
    .spi_clk    (spi_clk),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // One clock of time; outputs are sampled on the falling edge, then inputs may change.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (mon_en) begin
      check("busy", {31'd0, busy}, ((cyc >= b_start) && (cyc < b_end)) ? 1 : 0);
      if (data_valid || frame_err) begin
        if (rd_idx == wr_idx) begin
          check("spurious_pulse", {30'd0, data_valid, frame_err}, 0);
        end else begin
          check("pulse_kind", {30'd0, data_valid, frame_err}, e_err[rd_idx] ? 32'd1 : 32'd2);
          check("data_out", {20'd0, data_out}, {20'd0, e_data[rd_idx]});
          check("latency", cyc - e_cyc[rd_idx], S + 2);
          rd_idx++;
        end
      end
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) tick();
  endtask

  task automatic load_word(input logic [31:0] v, input int n);
    tx_bits.delete();
    for (int i = n - 1; i >= 0; i--) tx_bits.push_back(v[i]);
  endtask

  // Sends tx_bits as one frame; abort_at >= 0 pulses reset while that bit's clock is high.
  task automatic send_frame(input int half, input bit simul_end, input int abort_at, input int gap);
    int           n = tx_bits.size();
    bit           aborted = 1'b0;
    bit           simul = simul_end && (n > 0);
    logic [Q-1:0] word = '0;
    cs      = 1'b0;
    b_start = cyc + S + 2;
    b_end   = INF;
    for (int i = 0; i < n; i++) begin
      sdi  = tx_bits[i];
      word = {word[Q-2:0], tx_bits[i]};
      wait_cyc(half);
      spi_clk = 1'b1;
      if (simul && (i == n - 1)) break;
      if (i == abort_at) begin
        tick();
        reset   = 1'b1;
        b_end   = cyc + 1;
        m_held  = '0;
        aborted = 1'b1;
        tick();
        reset = 1'b0;
        wait_cyc(half - 2);
      end else begin
        wait_cyc(half);
      end
      spi_clk = 1'b0;
    end
    if (!simul) wait_cyc(half);
    cs = 1'b1;
    if (!aborted) begin
      b_end          = cyc + S + 2;
      e_err[wr_idx]  = (n != Q);
      if (n == Q) m_held = word;
      e_data[wr_idx] = m_held;
      e_cyc[wr_idx]  = cyc;
      wr_idx++;
    end
    if (simul) begin
      wait_cyc(half);
      spi_clk = 1'b0;
    end
    wait_cyc(gap);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    cs      = 1'b1;
    sdi     = 1'b0;
    spi_clk = 1'b0;
    wait_cyc(3);
    check("rst_data_out", {20'd0, data_out}, 0);
    check("rst_valid", {31'd0, data_valid}, 0);
    check("rst_err", {31'd0, frame_err}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    reset  = 1'b0;
    mon_en = 1'b1;
    wait_cyc(6);

    // Master-style frame with long phases
    load_word(32'hCCC, 12);
    send_frame(100, 1'b0, -1, 10);
    check("t1_data", {20'd0, data_out}, 32'hCCC);

    // Short frame
    load_word(32'h555, 11);
    send_frame(5, 1'b0, -1, 10);
    check("t2_hold", {20'd0, data_out}, 32'hCCC);

    // Overflow frame, all ones
    load_word(32'h1FFF, 13);
    send_frame(4, 1'b0, -1, 10);
    check("t3_hold", {20'd0, data_out}, 32'hCCC);

    // Reset mid-frame after 5 bits, then a clean frame
    load_word(32'h3C3, 12);
    send_frame(6, 1'b0, 4, 10);
    check("t4_rst_data", {20'd0, data_out}, 0);
    load_word(32'hA5A, 12);
    send_frame(5, 1'b0, -1, 10);
    check("t4_data", {20'd0, data_out}, 32'hA5A);

    // spi_clk activity with cs held high
    for (int i = 0; i < 20; i++) begin
      sdi     = 1'($urandom_range(0, 1));
      spi_clk = 1'b1;
      wait_cyc(4);
      spi_clk = 1'b0;
      wait_cyc(4);
    end
    check("t5_busy", {31'd0, busy}, 0);

    // Back-to-back frames, second ends with simultaneous clock rise and cs rise
    load_word(32'h001, 12);
    send_frame(3, 1'b0, -1, S + 1);
    load_word(32'h800, 12);
    send_frame(3, 1'b1, -1, 10);
    check("t6_data", {20'd0, data_out}, 32'h800);

    // Long frame whose bit count would wrap an unsaturated counter onto a match
    tx_bits.delete();
    for (int i = 0; i < (1 << CNT_W); i++) tx_bits.push_back(1'($urandom_range(0, 1)));
    for (int i = Q - 1; i >= 0; i--) tx_bits.push_back(1'((32'hABC >> i) & 1));
    send_frame(3, 1'b0, -1, 10);
    check("wrap_hold", {20'd0, data_out}, 32'h800);

    // Randomised frames
    for (int f = 0; f < 25; f++) begin
      int sel;
      int n;
      sel = $urandom_range(0, 5);
      case (sel)
        0, 1:    n = Q;
        2:       n = Q - 1;
        3:       n = Q + 1;
        4:       n = 0;
        default: n = $urandom_range(1, 20);
      endcase
      tx_bits.delete();
      for (int i = 0; i < n; i++) tx_bits.push_back(1'($urandom_range(0, 1)));
      send_frame($urandom_range(S + 1, S + 6), 1'($urandom_range(0, 1)), -1,
                 $urandom_range(S + 1, 10));
    end

    wait_cyc(20);
    check("drain", wr_idx - rd_idx, 0);
    check("final_data", {20'd0, data_out}, {20'd0, m_held});
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
